// File: rtl/bd_out_scheduler_if.sv
// Handshake bundle for the two-requester weighted output scheduler.
// slave is the scheduler side, master is the requester/sink side.
interface bd_out_scheduler_if #(
  parameter int N  = 21,
  parameter int NW = 8
);
  logic [N-1:0]  in0_d, in1_d, out_d;
  logic          in0_v, in0_a, in1_v, in1_a;
  logic          out_v, out_a;
  logic [NW-1:0] weight0, weight1;
  logic          stall;
  logic [1:0]    grant;

  modport slave (
    input  in0_d, in0_v, in1_d, in1_v, out_a, weight0, weight1, stall,
    output in0_a, in1_a, out_d, out_v, grant
  );
  modport master (
    output in0_d, in0_v, in1_d, in1_v, out_a, weight0, weight1, stall,
    input  in0_a, in1_a, out_d, out_v, grant
  );
endinterface

// File: rtl/bd_out_scheduler.sv
// Weighted burst scheduler: two requesters share a one-entry output register,
// each owner holds the grant for up to its weight in words.
module bd_out_scheduler #(
  parameter int N  = 21,
  parameter int NW = 8
) (
  input logic              clk,
  input logic              reset,
  bd_out_scheduler_if.slave b
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state, nxt;
  logic          last_served;
  logic [NW-1:0] credit, load_val;
  logic          load, leave;
  logic          slot_free, xfer0, xfer1, own_v, oth_v, own_x;

  function automatic logic [NW-1:0] eff_w(input logic [NW-1:0] w);
    return (w == '0) ? NW'(1) : w;
  endfunction

  assign slot_free = !b.out_v || b.out_a;
  assign b.in0_a   = (state == G0) && slot_free && !b.stall;
  assign b.in1_a   = (state == G1) && slot_free && !b.stall;
  assign xfer0     = b.in0_v && b.in0_a;
  assign xfer1     = b.in1_v && b.in1_a;
  assign own_v     = (state == G1) ? b.in1_v : b.in0_v;
  assign oth_v     = (state == G1) ? b.in0_v : b.in1_v;
  assign own_x     = xfer0 || xfer1;
  // a dry owner only releases when not stalled, so stall freezes the burst
  assign leave     = (state != IDLE) &&
                     ((own_x && credit == NW'(1)) || (!own_v && !b.stall));

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = eff_w(b.weight0);
    case (state)
      IDLE: if (!b.stall) begin
        if (b.in0_v && (!b.in1_v || last_served)) begin
          nxt = G0; load = 1'b1; load_val = eff_w(b.weight0);
        end else if (b.in1_v) begin
          nxt = G1; load = 1'b1; load_val = eff_w(b.weight1);
        end
      end
      default: if (leave) begin
        if (oth_v) begin
          nxt      = (state == G0) ? G1 : G0;
          load     = 1'b1;
          load_val = (state == G0) ? eff_w(b.weight1) : eff_w(b.weight0);
        end else if (own_v) begin
          load     = 1'b1;
          load_val = (state == G0) ? eff_w(b.weight0) : eff_w(b.weight1);
        end else begin
          nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      last_served <= 1'b1;
      b.grant     <= 2'b00;
      b.out_v     <= 1'b0;
      b.out_d     <= '0;
    end else begin
      state   <= nxt;
      b.grant <= {nxt == G1, nxt == G0};
      if (load)       credit <= load_val;
      else if (own_x) credit <= credit - NW'(1);
      if (leave)      last_served <= (state == G1);
      if (xfer0) begin
        b.out_d <= b.in0_d; b.out_v <= 1'b1;
      end else if (xfer1) begin
        b.out_d <= b.in1_d; b.out_v <= 1'b1;
      end else if (b.out_a) begin
        b.out_v <= 1'b0;
      end
    end
  end
endmodule

// File: doc/bd_out_scheduler.md
BD_OUT_SCHEDULER -- requirements
Module: bd_out_scheduler

Interface
REQ-001 SHALL have parameter N, default 21, data width of every channel.
REQ-002 SHALL have parameter NW, default 8, width of each weight input.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in0_d  input  N  requester 0 data.
REQ-006 SHALL have port in0_v  input  1  requester 0 valid.
REQ-007 SHALL have port in0_a  output  1  requester 0 ack.
REQ-008 SHALL have ports in1_d, in1_v, in1_a with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port out_d  output  N  scheduled data, registered.
REQ-010 SHALL have port out_v  output  1  output valid, registered.
REQ-011 SHALL have port out_a  input  1  downstream ack.
REQ-012 SHALL have port weight0  input  NW  burst credit for requester 0.
REQ-013 SHALL have port weight1  input  NW  burst credit for requester 1.
REQ-014 SHALL have port stall  input  1  blocks acceptance of new words.
REQ-015 SHALL have port grant  output  2  one-hot current owner: bit k set in state Gk, 00 in IDLE.

Function
REQ-016 A transfer on any channel SHALL occur on a rising edge where v=1 and a=1 for that channel.
REQ-017 The output SHALL be a one-entry register; a word SHALL appear on out_d/out_v exactly 1 cycle after its input transfer.
REQ-018 A slot SHALL be defined as free when out_v=0 or out_a=1.
REQ-019 ink_a SHALL be combinational and SHALL equal (state==Gk) AND slot free AND NOT stall; the ack of the non-owning requester SHALL be 0.
REQ-020 While out_v=1 and out_a=0, out_d SHALL be held stable.
REQ-021 out_v SHALL clear on an edge with out_a=1 and no input transfer.
REQ-022 The state machine SHALL have exactly three states: IDLE, G0, G1.
REQ-023 The scheduler SHALL keep a last_served bit and an NW-bit credit counter.
REQ-024 IDLE, stall=0: if both requesters are valid, SHALL enter G(NOT last_served); if only one is valid, SHALL enter that one's state; otherwise SHALL remain in IDLE.
REQ-025 IDLE, stall=1: SHALL remain in IDLE.
REQ-026 On entering Gk, credit SHALL load weightk, with a weight of 0 loaded as 1.
REQ-027 Each transfer from requester k SHALL decrement credit by 1.
REQ-028 Gk SHALL be left on an edge where a transfer occurs with credit==1, or where ink_v=0 and stall=0; last_served SHALL then be set to k.
REQ-029 On leaving Gk: if the other requester is valid, SHALL go directly to G(other) and reload its credit.
REQ-030 On leaving Gk with the other requester not valid: if ink_v=1, SHALL re-enter Gk and reload credit; otherwise SHALL go to IDLE.
REQ-031 Gk, stall=1: the state and credit SHALL be held and no ack SHALL be issued; the burst SHALL resume with the remaining credit when stall falls.
REQ-032 stall SHALL NOT block draining of the output register.
REQ-033 A weight change during a burst SHALL take effect only at the next credit load.
REQ-034 Word order within each requester SHALL be preserved; no word SHALL be duplicated or dropped.

Reset
REQ-035 reset=1 SHALL immediately, without a clock edge, force: state IDLE, out_v=0, out_d=0, in0_a=in1_a=0, grant=00, credit=0, last_served=1.
REQ-036 A word held in the output register at reset SHALL be discarded.
REQ-037 After reset release, requester 0 SHALL win the first tie.

Verification
REQ-038 Scenario: weight0=2, weight1=1, both requesters always valid, out_a=1 -> out source order 0,0,1,0,0,1,... with one word per cycle and no bubbles.
REQ-039 Scenario: only in1 valid with 5 words, weight1=2 -> all 5 words appear in order on 5 consecutive cycles, re-granted without passing through IDLE.
REQ-040 Scenario: out_a=0 for 10 cycles with both requesters valid -> out_d stable, one word held, in0_a=in1_a=0; all words are delivered after out_a=1.
REQ-041 Scenario: stall=1 for 4 cycles mid-burst in G0 with credit=3 -> no acks and grant=01 held; the burst then completes exactly 3 more in0 words.
REQ-042 Scenario: weight0=weight1=0, both requesters valid -> strict alternation 0,1,0,1.
REQ-043 Scenario: reset asserted between clock edges during a burst -> out_v, acks and grant are 0 before the next edge; the first tie after release goes to requester 0.
